// File: rtl/sram_column_reader.sv
// Read side of the NLM line-buffer SRAM controller: aligns the issued read controls with SRAM data,
// rotates the line SRAM outputs into a top-to-bottom pixel column, mirror-pads it and tracks frame position.
module sram_column_reader #(
   parameter int BLOCK_RADIUS = 2,
   parameter int WIN_RADIUS   = 6,
   parameter int DATA_WIDTH   = 12,
   parameter int IMAGE_WIDTH  = 4032,
   parameter int IMAGE_HEIGHT = 3024,
   parameter int SRAM_LAT     = 1,
   localparam int SRAM_SIZE   = 2*(BLOCK_RADIUS+WIN_RADIUS+1),
   localparam int COL_SIZE    = 2*(BLOCK_RADIUS+WIN_RADIUS)+1,
   localparam int CENTER      = BLOCK_RADIUS+WIN_RADIUS
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           frame_sync_i,
   input  logic                           line_sync_i,
   input  logic                           valid_i,
   input  logic [SRAM_SIZE-1:0]           sram_rden_i,
   input  logic [4:0]                     head_num_i,
   input  logic [SRAM_SIZE*DATA_WIDTH-1:0] sram_rdata_i,
   output logic [COL_SIZE*DATA_WIDTH-1:0] col_o,
   output logic                           col_valid_o,
   output logic [11:0]                    col_x_o,
   output logic [11:0]                    row_y_o,
   output logic                           frame_done_o,
   output logic                           err_o
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic                  validPipe_q [SRAM_LAT];
   logic [SRAM_SIZE-1:0]  rdenPipe_q  [SRAM_LAT];
   logic [4:0]            headPipe_q  [SRAM_LAT];

   logic [DATA_WIDTH-1:0] sramWord    [SRAM_SIZE];
   logic [5:0]            sumIdx      [COL_SIZE];
   logic [4:0]            selIdx      [COL_SIZE];
   logic [DATA_WIDTH-1:0] slot_d      [COL_SIZE];
   logic [DATA_WIDTH-1:0] slot_q      [COL_SIZE];
   logic [COL_SIZE-1:0]   en_d;
   logic [COL_SIZE-1:0]   en_q;
   logic                  bValid_q;

   logic [DATA_WIDTH-1:0]          colWord_d [COL_SIZE];
   logic [COL_SIZE*DATA_WIDTH-1:0] col_d;
   logic                           colValid_d;
   logic                           errSet_d;

   state_t      state_q, state_d;
   logic [11:0] x_q, x_d;
   logic [11:0] y_q, y_d;
   logic [11:0] colX_d, rowY_d;
   logic        frameDone_d;
   logic        frameStart;

   // Read controls travel alongside the SRAM access so they meet the returned data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SRAM_LAT; i++) begin
            validPipe_q[i] <= 1'b0;
            rdenPipe_q[i]  <= '0;
            headPipe_q[i]  <= '0;
         end
      end else begin
         validPipe_q[0] <= valid_i;
         rdenPipe_q[0]  <= sram_rden_i;
         headPipe_q[0]  <= head_num_i;
         for (int i = 1; i < SRAM_LAT; i++) begin
            validPipe_q[i] <= validPipe_q[i-1];
            rdenPipe_q[i]  <= rdenPipe_q[i-1];
            headPipe_q[i]  <= headPipe_q[i-1];
         end
      end
   end

   for (genvar j = 0; j < SRAM_SIZE; j++) begin : g_word
      assign sramWord[j] = sram_rdata_i[j*DATA_WIDTH +: DATA_WIDTH];
   end

   // Slot k reads the line (head+k) wrapped once; head is always below SRAM_SIZE
   for (genvar k = 0; k < COL_SIZE; k++) begin : g_rotate
      assign sumIdx[k] = {1'b0, headPipe_q[SRAM_LAT-1]} + 6'(k);
      assign selIdx[k] = (sumIdx[k] >= 6'(SRAM_SIZE)) ? 5'(sumIdx[k] - 6'(SRAM_SIZE)) : sumIdx[k][4:0];
      assign slot_d[k] = sramWord[selIdx[k]];
      assign en_d[k]   = rdenPipe_q[SRAM_LAT-1][selIdx[k]];
   end

   for (genvar k = 0; k < COL_SIZE; k++) begin : g_pad
      localparam int MIRROR = 2*CENTER - k;
      assign colWord_d[k] = en_q[k]      ? slot_q[k]      :
                            en_q[MIRROR] ? slot_q[MIRROR] : slot_q[CENTER];
      assign col_d[k*DATA_WIDTH +: DATA_WIDTH] = colWord_d[k];
   end

   assign colValid_d = bValid_q & en_q[CENTER];
   assign errSet_d   = bValid_q & ~en_q[CENTER];
   assign frameStart = frame_sync_i & line_sync_i;

   // A frame start outranks column counting; columns seen in IDLE are labelled 0/0
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      frameDone_d = 1'b0;
      colX_d      = (state_q == ACTIVE) ? x_q : 12'd0;
      rowY_d      = (state_q == ACTIVE) ? y_q : 12'd0;
      if (frameStart) begin
         state_d = ACTIVE;
         x_d     = 12'd0;
         y_d     = 12'd0;
      end else if (state_q == ACTIVE && colValid_d) begin
         if (x_q == 12'(IMAGE_WIDTH-1)) begin
            x_d = 12'd0;
            if (y_q == 12'(IMAGE_HEIGHT-1)) begin
               y_d         = 12'd0;
               state_d     = IDLE;
               frameDone_d = 1'b1;
            end else begin
               y_d = y_q + 12'd1;
            end
         end else begin
            x_d = x_q + 12'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bValid_q     <= 1'b0;
         en_q         <= '0;
         for (int k = 0; k < COL_SIZE; k++) begin
            slot_q[k] <= '0;
         end
         col_o        <= '0;
         col_valid_o  <= 1'b0;
         col_x_o      <= '0;
         row_y_o      <= '0;
         frame_done_o <= 1'b0;
         err_o        <= 1'b0;
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
      end else begin
         bValid_q     <= validPipe_q[SRAM_LAT-1];
         en_q         <= en_d;
         for (int k = 0; k < COL_SIZE; k++) begin
            slot_q[k] <= slot_d[k];
         end
         col_o        <= col_d;
         col_valid_o  <= colValid_d;
         col_x_o      <= colX_d;
         row_y_o      <= rowY_d;
         frame_done_o <= frameDone_d;
         err_o        <= err_o | errSet_d;
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
      end
   end

endmodule

// File: tb/tb_sram_column_reader.sv
// Self-checking bench for sram_column_reader: directed column cases, randomized reads against
// a modulo-arithmetic reference model, and frame accounting on a 4x3 image.
module tb_sram_column_reader;

   localparam int SS = 18;
   localparam int CS = 17;
   localparam int CT = 8;
   localparam int DW = 12;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              frame_sync_i;
   logic              line_sync_i;
   logic              valid_i;
   logic [SS-1:0]     sram_rden_i;
   logic [4:0]        head_num_i;
   logic [SS*DW-1:0]  sram_rdata_i;
   logic [CS*DW-1:0]  col_o;
   logic              col_valid_o;
   logic [11:0]       col_x_o;
   logic [11:0]       row_y_o;
   logic              frame_done_o;
   logic              err_o;

   int checks = 0;
   int errors = 0;
   logic [SS*DW-1:0] pendingData;

   sram_column_reader #(
      .IMAGE_WIDTH (4),
      .IMAGE_HEIGHT(3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_sync_i(frame_sync_i),
      .line_sync_i (line_sync_i),
      .valid_i     (valid_i),
      .sram_rden_i (sram_rden_i),
      .head_num_i  (head_num_i),
      .sram_rdata_i(sram_rdata_i),
      .col_o       (col_o),
      .col_valid_o (col_valid_o),
      .col_x_o     (col_x_o),
      .row_y_o     (row_y_o),
      .frame_done_o(frame_done_o),
      .err_o       (err_o)
   );

   always #5 clk = ~clk;

   // One issue cycle: the SRAM answers the previous cycle's read while this read is issued
   task automatic applyStimulus(input logic v, input logic [SS-1:0] rden, input int head, input logic [SS*DW-1:0] data);
      valid_i      = v;
      sram_rden_i  = rden;
      head_num_i   = 5'(head);
      sram_rdata_i = pendingData;
      pendingData  = data;
      @(negedge clk);
   endtask

   function automatic logic [SS*DW-1:0] rampData(input int base);
      logic [SS*DW-1:0] d;
      d = '0;
      for (int j = 0; j < SS; j++) d[j*DW +: DW] = 12'(base + j);
      return d;
   endfunction

   function automatic logic [SS*DW-1:0] randomData();
      logic [SS*DW-1:0] d;
      d = '0;
      for (int j = 0; j < SS; j++) d[j*DW +: DW] = 12'($urandom);
      return d;
   endfunction

   // Reference: rotate by modulo, then take own row, else mirrored row, else centre row
   function automatic logic [CS*DW-1:0] modelColumn(input logic [SS-1:0] rden, input int head, input logic [SS*DW-1:0] data);
      logic [DW-1:0]    word [CS];
      logic             en   [CS];
      logic [CS*DW-1:0] c;
      int               s;
      c = '0;
      for (int k = 0; k < CS; k++) begin
         s       = (head + k) % SS;
         word[k] = data[s*DW +: DW];
         en[k]   = rden[s];
      end
      for (int k = 0; k < CS; k++) begin
         if (en[k])              c[k*DW +: DW] = word[k];
         else if (en[2*CT - k])  c[k*DW +: DW] = word[2*CT - k];
         else                    c[k*DW +: DW] = word[CT];
      end
      return c;
   endfunction

   task automatic test_reset(input bit midStream);
      if (midStream) begin
         for (int i = 0; i < 3; i++) applyStimulus(1'b1, 18'h1FFFF, 0, rampData(i));
      end
      rst_n = 1'b0;
      applyStimulus(1'b0, '0, 0, '0);
      applyStimulus(1'b0, '0, 0, '0);
      checks++;
      if (col_valid_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_hold_valid: got %b expected 0", col_valid_o);
      end
      rst_n = 1'b1;
      pendingData = '0;
      applyStimulus(1'b0, '0, 0, '0);
      checks++;
      if (col_valid_o !== 1'b0 || col_o !== '0 || err_o !== 1'b0 || frame_done_o !== 1'b0 ||
          col_x_o !== 12'd0 || row_y_o !== 12'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got valid=%b col=%h err=%b done=%b x=%0d y=%0d expected all 0",
                  col_valid_o, col_o, err_o, frame_done_o, col_x_o, row_y_o);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, '0, 0, '0);
         checks++;
         if (col_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pipe_discard: got %b expected 0", col_valid_o);
         end
      end
   endtask

   task automatic test_full_window();
      logic [CS*DW-1:0] exp;
      for (int k = 0; k < CS; k++) exp[k*DW +: DW] = 12'(k);
      applyStimulus(1'b1, 18'h1FFFF, 0, rampData(0));
      applyStimulus(1'b0, '0, 0, '0);
      checks++;
      if (col_valid_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL full_window_early: got valid=%b expected 0", col_valid_o);
      end
      applyStimulus(1'b0, '0, 0, '0);
      checks++;
      if (col_valid_o !== 1'b1 || col_o !== exp) begin
         errors++;
         $display("[TB] FAIL full_window: got valid=%b col=%h expected valid=1 col=%h", col_valid_o, col_o, exp);
      end
      applyStimulus(1'b0, '0, 0, '0);
      checks++;
      if (col_valid_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL full_window_gap: got valid=%b expected 0", col_valid_o);
      end
   endtask

   task automatic test_rotation();
      logic [CS*DW-1:0] exp;
      for (int k = 0; k < CS; k++) exp[k*DW +: DW] = (k < 8) ? 12'(10 + k) : 12'(k - 8);
      applyStimulus(1'b1, 18'h3FDFF, 10, rampData(0));
      applyStimulus(1'b0, '0, 0, '0);
      applyStimulus(1'b0, '0, 0, '0);
      checks++;
      if (col_valid_o !== 1'b1 || col_o !== exp) begin
         errors++;
         $display("[TB] FAIL rotation_wrap: got valid=%b col=%h expected valid=1 col=%h", col_valid_o, col_o, exp);
      end
   endtask

   task automatic test_top_mirror();
      logic [CS*DW-1:0] exp;
      for (int k = 0; k < CS; k++) exp[k*DW +: DW] = (k < 4) ? 12'(116 - k) : 12'(100 + k);
      applyStimulus(1'b1, 18'h1FFF0, 0, rampData(100));
      applyStimulus(1'b0, '0, 0, '0);
      applyStimulus(1'b0, '0, 0, '0);
      checks++;
      if (col_valid_o !== 1'b1 || col_o !== exp) begin
         errors++;
         $display("[TB] FAIL top_mirror: got valid=%b col=%h expected valid=1 col=%h", col_valid_o, col_o, exp);
      end
   endtask

   task automatic test_random();
      logic             expValidQ [$];
      logic [CS*DW-1:0] expColQ   [$];
      logic             v;
      logic             ev;
      logic [CS*DW-1:0] ec;
      logic [SS-1:0]    rden;
      logic [SS*DW-1:0] data;
      int               head;
      for (int i = 0; i < 62; i++) begin
         v    = (i < 60) && ($urandom_range(0, 3) != 0);
         head = $urandom_range(0, SS-1);
         rden = 18'($urandom);
         rden[(head + CT) % SS] = 1'b1;
         data = randomData();
         expValidQ.push_back(v);
         expColQ.push_back(modelColumn(rden, head, data));
         applyStimulus(v, rden, head, data);
         if (expValidQ.size() == 3) begin
            ev = expValidQ.pop_front();
            ec = expColQ.pop_front();
            checks++;
            if (col_valid_o !== ev || err_o !== 1'b0) begin
               errors++;
               $display("[TB] FAIL random_valid: got valid=%b err=%b expected valid=%b err=0", col_valid_o, err_o, ev);
            end
            if (ev) begin
               checks++;
               if (col_o !== ec) begin
                  errors++;
                  $display("[TB] FAIL random_column: got %h expected %h", col_o, ec);
               end
            end
         end
      end
   endtask

   task automatic test_frame();
      logic v;
      logic ev;
      int   j;
      int   doneCount;
      doneCount = 0;
      for (int i = 0; i < 20; i++) begin
         v = (i >= 1 && i <= 12) || i == 16 || i == 17;
         frame_sync_i = (i == 0);
         line_sync_i  = (i == 0);
         applyStimulus(v, 18'h1FFFF, 0, rampData(i));
         frame_sync_i = 1'b0;
         line_sync_i  = 1'b0;
         if (frame_done_o === 1'b1) doneCount++;
         j = i - 2;
         if (j >= 0) begin
            ev = (j >= 1 && j <= 12) || j == 16 || j == 17;
            checks++;
            if (col_valid_o !== ev || frame_done_o !== (j == 12)) begin
               errors++;
               $display("[TB] FAIL frame_valid_done[%0d]: got valid=%b done=%b expected valid=%b done=%b",
                        j, col_valid_o, frame_done_o, ev, (j == 12));
            end
            if (ev) begin
               checks++;
               if (j <= 12 && (col_x_o !== 12'((j - 1) % 4) || row_y_o !== 12'((j - 1) / 4))) begin
                  errors++;
                  $display("[TB] FAIL frame_xy[%0d]: got x=%0d y=%0d expected x=%0d y=%0d",
                           j, col_x_o, row_y_o, (j - 1) % 4, (j - 1) / 4);
               end else if (j > 12 && (col_x_o !== 12'd0 || row_y_o !== 12'd0)) begin
                  errors++;
                  $display("[TB] FAIL frame_idle_xy[%0d]: got x=%0d y=%0d expected x=0 y=0", j, col_x_o, row_y_o);
               end
            end
         end
      end
      checks++;
      if (doneCount != 1) begin
         errors++;
         $display("[TB] FAIL frame_done_count: got %0d expected 1", doneCount);
      end
   endtask

   task automatic test_centre_missing();
      applyStimulus(1'b1, 18'h1FEFF, 0, rampData(0));
      applyStimulus(1'b1, 18'h1FFFF, 0, rampData(50));
      applyStimulus(1'b0, '0, 0, '0);
      checks++;
      if (col_valid_o !== 1'b0 || err_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL centre_missing: got valid=%b err=%b expected valid=0 err=1", col_valid_o, err_o);
      end
      applyStimulus(1'b0, '0, 0, '0);
      checks++;
      if (col_valid_o !== 1'b1 || err_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL centre_next_good: got valid=%b err=%b expected valid=1 err=1", col_valid_o, err_o);
      end
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 0, '0);
      checks++;
      if (err_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL err_sticky: got %b expected 1", err_o);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      frame_sync_i = 1'b0;
      line_sync_i  = 1'b0;
      valid_i      = 1'b0;
      sram_rden_i  = '0;
      head_num_i   = '0;
      sram_rdata_i = '0;
      pendingData  = '0;
      test_reset(1'b0);
      test_full_window();
      test_rotation();
      test_top_mirror();
      test_random();
      test_frame();
      test_centre_missing();
      test_reset(1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_column_reader.md
Name: sram_column_reader

Overview:
- Read-side companion of the NLM line-buffer SRAM controller.
- Takes the 18 SRAM read-data buses, the rotated read-enable mask and the head index issued with each read address. Delays them to match the SRAM read latency.
- Rotates the SRAM outputs into a top-to-bottom column of 2*(BLOCK_RADIUS+WIN_RADIUS)+1 pixels and applies mirror padding for rows outside the image.
- Feeds the window shift-register array of the NLM datapath and tracks column/row position per frame.

Parameters:
BLOCK_RADIUS, 2, block (patch) radius
WIN_RADIUS, 6, search-window radius
DATA_WIDTH, 12, pixel width
IMAGE_WIDTH, 4032, pixels per line
IMAGE_HEIGHT, 3024, lines per frame
SRAM_SIZE, 2*(BLOCK_RADIUS+WIN_RADIUS+1) = 18, number of line SRAMs (derived, not overridden)
COL_SIZE, 2*(BLOCK_RADIUS+WIN_RADIUS)+1 = 17, output column height (derived)
CENTER, BLOCK_RADIUS+WIN_RADIUS = 8, index of the centre slot (derived)
SRAM_LAT, 1, SRAM read latency in cycles

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
frame_sync_i  in  1  frame start, qualified with line_sync_i
line_sync_i  in  1  line start pulse
valid_i  in  1  read issued this cycle (aligned with rden/addr)
sram_rden_i  in  SRAM_SIZE  read-enable mask issued this cycle
head_num_i  in  5  index of oldest buffered line, 0..SRAM_SIZE-1
sram_rdata_i  in  SRAM_SIZE*DATA_WIDTH  read data; SRAM j at bits [j*DATA_WIDTH +: DATA_WIDTH]
col_o  out  COL_SIZE*DATA_WIDTH  column; slot 0 = top row, at bits [0 +: DATA_WIDTH]
col_valid_o  out  1  col_o valid
col_x_o  out  12  column index of col_o, 0..IMAGE_WIDTH-1
row_y_o  out  12  centre-row index of col_o, 0..IMAGE_HEIGHT-1
frame_done_o  out  1  one-cycle pulse with the last column of a frame
err_o  out  1  sticky error: centre SRAM not enabled on a valid read

Behaviour:
- Reset (rst_n=0 at posedge):
  - All outputs clear to 0; FSM goes to IDLE; delay pipes and counters clear.
  - Reset mid-frame aborts immediately. No frame_done_o is issued.
- Stage A, SRAM_LAT cycles:
  - valid_i, sram_rden_i and head_num_i pass through a SRAM_LAT-deep register pipe.
  - The pipe output is aligned with sram_rdata_i.
- Stage B, rotate (registered):
  - Slot k (0..COL_SIZE-1) takes SRAM s = (head+k) mod SRAM_SIZE. The modulo is computed as head+k, minus SRAM_SIZE if the sum is >= SRAM_SIZE. No divider is used.
  - en[k] = rden[s].
  - SRAM (head+COL_SIZE) mod SRAM_SIZE is the write line and is never used.
- Stage C, pad (registered):
  - If en[k]=1, out[k] = slot[k].
  - Else if en[2*CENTER-k]=1, out[k] = slot[2*CENTER-k] (mirror).
  - Else out[k] = slot[CENTER] (replicate).
  - If en[CENTER]=0 while valid: col_valid_o is forced 0 and err_o is set. err_o clears only on reset.
- Latency: col_valid_o rises exactly SRAM_LAT+2 cycles after the corresponding valid_i. Throughput is 1 column per cycle. Gaps in valid_i propagate unchanged.
- FSM:
  - IDLE -> ACTIVE on frame_sync_i & line_sync_i. Counters load x=0, y=0.
  - ACTIVE:
    - Each output column increments x.
    - At x=IMAGE_WIDTH-1, x wraps to 0 and y increments.
    - ACTIVE -> IDLE on the column with x=IMAGE_WIDTH-1 and y=IMAGE_HEIGHT-1. frame_done_o pulses with that column.
  - frame_sync_i & line_sync_i while ACTIVE restarts counters at 0 and stays ACTIVE. No frame_done_o is issued.
- Columns arriving in IDLE are still output with col_valid_o=1, but x/y hold 0. This is a diagnostic path only.
- col_x_o and row_y_o are registered with col_o. Widths are fixed at 12 bits, which covers 4032.

Test Plan:
- Reset: rst_n=0 for 2 cycles mid-stream -> next cycle col_valid_o=0, col_o=0, err_o=0, FSM IDLE. Pipe contents are discarded.
- Full window: head=0, rden=18'h1FFFF, SRAM j holds value j, valid_i=1 -> 3 cycles later col_valid_o=1, slot k = k (0..16).
- Rotation/wrap: head=10, all SRAMs enabled except 9, SRAM j = j -> slots = 10..17, 0..8. Slot 8 = 0, slot 16 = 8.
- Top mirror: head=0, rden bits 0..3 cleared, SRAM j = 100+j -> slots 0..3 = 116, 115, 114, 113; slots 4..16 unchanged.
- Centre missing: rden bit 8 cleared with head=0, valid_i=1 -> col_valid_o stays 0, err_o=1 and held until reset.
- Frame accounting (IMAGE_WIDTH=4, IMAGE_HEIGHT=3 override): frame sync, then 12 valid reads -> col_x_o cycles 0..3, row_y_o 0..2. frame_done_o pulses once, on the 12th column. FSM returns to IDLE.
